// File: rtl/dp3_pkg.sv
// Shared types and constants for the 3-sequence affine-gap DP plane buffer.
package dp3_pkg;

  localparam int W       = 12;
  localparam int G0      = 2;
  localparam int GE      = 1;
  localparam int NEG_INF = -1024;

  typedef logic signed [W-1:0] score_t;

  localparam score_t NegInfS = W'(NEG_INF);

  typedef struct packed {
    score_t m;
    score_t ixy;
    score_t iyz;
    score_t ixz;
    score_t ix;
    score_t iy;
    score_t iz;
  } score_vec_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRead,
    StPresent,
    StWaitRes,
    StDone
  } state_e;

  // Gap-open on both y and z, then extend along the j+k-1 remaining steps.
  function automatic score_t iyz_boundary(int j, int k);
    int v;
    v = -(2 * G0 + 2 * GE * (j + k - 1));
    if (v < NEG_INF) v = NEG_INF;
    return W'(v);
  endfunction

endpackage

// File: rtl/dp3_plane_buffer_if.sv
// Neighbour (nb_*) and result (res_*) channels between the plane buffer and the DP stage.
interface dp3_plane_buffer_if import dp3_pkg::*; #(
  parameter int unsigned LI = 16,
  parameter int unsigned LJ = 16,
  parameter int unsigned LK = 16
);
  logic                      nb_valid;
  logic                      nb_ready;
  score_vec_t                nb_scores;
  logic [$clog2(LI+1)-1:0]   nb_i;
  logic [$clog2(LJ+1)-1:0]   nb_j;
  logic [$clog2(LK+1)-1:0]   nb_k;
  logic                      res_valid;
  logic                      res_ready;
  score_vec_t                res_scores;

  modport master (
    output nb_valid, nb_scores, nb_i, nb_j, nb_k, res_ready,
    input  nb_ready, res_valid, res_scores
  );

  modport slave (
    input  nb_valid, nb_scores, nb_i, nb_j, nb_k, res_ready,
    output nb_ready, res_valid, res_scores
  );
endinterface

// File: rtl/dp3_plane_ram.sv
// 1R1W plane store: synchronous read into a registered output; contents are not reset.
module dp3_plane_ram import dp3_pkg::*; #(
  parameter int unsigned Depth = 289,
  parameter int unsigned Aw    = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  score_vec_t    wdata_i,
  input  logic          re_i,
  input  logic [Aw-1:0] raddr_i,
  output score_vec_t    rdata_o
);
  score_vec_t mem [Depth];
  score_vec_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dp3_plane_buffer.sv
// Previous-plane store and (i,j,k) raster sweep sequencer for the 3D DP array.
// Build macro BOUNDARY_INIT_EN selects affine-gap Iyz boundary values in plane 0.
module dp3_plane_buffer import dp3_pkg::*; #(
  parameter int unsigned LJ = 16,
  parameter int unsigned LK = 16,
  parameter int unsigned LI = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(LI+1)-1:0] cfg_ni,
  input  logic [$clog2(LJ+1)-1:0] cfg_nj,
  input  logic [$clog2(LK+1)-1:0] cfg_nk,
  output logic                    busy,
  output logic                    done,
  dp3_plane_buffer_if.master      bus
);
  localparam int unsigned IW    = $clog2(LI + 1);
  localparam int unsigned JW    = $clog2(LJ + 1);
  localparam int unsigned KW    = $clog2(LK + 1);
  localparam int unsigned DEPTH = (LJ + 1) * (LK + 1);
  localparam int unsigned AW    = $clog2(DEPTH);

  state_e         state_q, state_d;
  logic [IW-1:0]  i_q, i_d, ni_q, ni_d;
  logic [JW-1:0]  j_q, j_d, nj_q, nj_d;
  logic [KW-1:0]  k_q, k_d, nk_q, nk_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           nb_valid_q, nb_valid_d, res_ready_q, res_ready_d;
  logic           ram_we, ram_re, last_j, last_k;
  logic [AW-1:0]  addr;
  score_vec_t     ram_wdata, ram_rdata;

  function automatic score_vec_t init_vec(logic [JW-1:0] j, logic [KW-1:0] k);
    score_vec_t v;
    v = {7{NegInfS}};
    if (j == '0 && k == '0) v.m = '0;
`ifdef BOUNDARY_INIT_EN
    else v.iyz = iyz_boundary(int'(j), int'(k));
`endif
    return v;
  endfunction

  assign addr   = AW'(j_q) * AW'(LK + 1) + AW'(k_q);
  assign last_j = (j_q == nj_q);
  assign last_k = (k_q == nk_q);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    ni_d      = ni_q;
    nj_d      = nj_q;
    nk_d      = nk_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = init_vec(j_q, k_q);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ni_d    = cfg_ni;
          nj_d    = cfg_nj;
          nk_d    = cfg_nk;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        ram_we = 1'b1;
        if (!last_k) begin
          k_d = k_q + 1'b1;
        end else begin
          k_d = '0;
          if (!last_j) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (ni_q == '0) begin
              state_d = StDone;
            end else begin
              i_d     = IW'(1);
              state_d = StRead;
            end
          end
        end
      end
      StRead: begin
        ram_re  = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        if (bus.nb_ready) state_d = StWaitRes;
      end
      StWaitRes: begin
        if (bus.res_valid) begin
          ram_we    = 1'b1;
          ram_wdata = bus.res_scores;
          state_d   = StRead;
          if (!last_k) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            if (!last_j) begin
              j_d = j_q + 1'b1;
            end else if (i_q == ni_q) begin
              // Coordinates hold at the last cell; nothing reads them after DONE.
              k_d     = k_q;
              state_d = StDone;
            end else begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    nb_valid_d  = (state_d == StPresent);
    res_ready_d = (state_d == StWaitRes);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      ni_q        <= '0;
      nj_q        <= '0;
      nk_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nb_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      ni_q        <= ni_d;
      nj_q        <= nj_d;
      nk_q        <= nk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nb_valid_q  <= nb_valid_d;
      res_ready_q <= res_ready_d;
    end
  end

  dp3_plane_ram #(
    .Depth (DEPTH),
    .Aw    (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (ram_we),
    .waddr_i (addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (addr),
    .rdata_o (ram_rdata)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.nb_valid  = nb_valid_q;
  assign bus.res_ready = res_ready_q;
  assign bus.nb_scores = ram_rdata;
  assign bus.nb_i      = i_q;
  assign bus.nb_j      = j_q;
  assign bus.nb_k      = k_q;
endmodule

// File: tb/tb_dp3_plane_buffer.sv
// Scoreboard bench for dp3_plane_buffer: a plane-array model predicts every neighbour vector.
// Honours BOUNDARY_INIT_EN for the expected plane-0 contents.
module tb_dp3_plane_buffer;
  import dp3_pkg::*;

  localparam int NEG = -1024;

  typedef struct {
    int         i;
    int         j;
    int         k;
    score_vec_t sc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] cfg_ni, cfg_nj, cfg_nk;
  logic       busy, done;

  dp3_plane_buffer_if #(.LI(16), .LJ(16), .LK(16)) bus ();

  dp3_plane_buffer #(.LJ(16), .LK(16), .LI(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cfg_ni (cfg_ni),
    .cfg_nj (cfg_nj),
    .cfg_nk (cfg_nk),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  score_vec_t res_q[$];
  score_vec_t plane [0:16][0:16];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         stall_len = 0;
  bit         drv_en = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic score_vec_t rand_vec();
    score_vec_t v;
    v.m   = 12'($urandom);
    v.ixy = 12'($urandom);
    v.iyz = 12'($urandom);
    v.ixz = 12'($urandom);
    v.ix  = 12'($urandom);
    v.iy  = 12'($urandom);
    v.iz  = 12'($urandom);
    return v;
  endfunction

  function automatic score_vec_t all_neg();
    score_vec_t v;
    v.m = 12'(NEG); v.ixy = 12'(NEG); v.iyz = 12'(NEG); v.ixz = 12'(NEG);
    v.ix = 12'(NEG); v.iy = 12'(NEG); v.iz = 12'(NEG);
    return v;
  endfunction

  // Plane 0 from the boundary rules, then walk every cell reading and replacing plane[j][k].
  task automatic build_model(int ni, int nj, int nk, bit directed);
    exp_t       e;
    score_vec_t r;
    bit         first = 1'b1;
    for (int j = 0; j <= nj; j++) begin
      for (int k = 0; k <= nk; k++) begin
        plane[j][k] = all_neg();
        if (j == 0 && k == 0) plane[j][k].m = 12'(0);
`ifdef BOUNDARY_INIT_EN
        else begin
          int b;
          b = -(4 + 2 * (j + k - 1));
          if (b < NEG) b = NEG;
          plane[j][k].iyz = 12'(b);
        end
`endif
      end
    end
    for (int i = 1; i <= ni; i++) begin
      for (int j = 0; j <= nj; j++) begin
        for (int k = 0; k <= nk; k++) begin
          e.i = i; e.j = j; e.k = k; e.sc = plane[j][k];
          exp_q.push_back(e);
          r = rand_vec();
          if (directed && first) begin
            r = all_neg();
            r.m  = 12'(37);
            r.ix = 12'(-5);
          end
          first = 1'b0;
          res_q.push_back(r);
          plane[j][k] = r;
        end
      end
    end
  endtask

  // Consumer side: stalls nb_ready for stall_len cycles, then random ready; random res_valid.
  initial begin
    int stall_cnt = 0;
    bus.nb_ready   = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_scores = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!drv_en) begin
        bus.nb_ready  = 1'b0;
        bus.res_valid = 1'b0;
        stall_cnt     = 0;
      end else begin
        stall_cnt     = bus.nb_valid ? stall_cnt + 1 : 0;
        bus.nb_ready  = (stall_cnt > stall_len) && ($urandom_range(0, 3) != 0);
        bus.res_valid = (res_q.size() > 0) && ($urandom_range(0, 3) != 0);
        if (res_q.size() > 0) bus.res_scores = res_q[0];
      end
    end
  end

  // Monitor: compares every presented neighbour vector, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.nb_valid) begin
        if (exp_q.size() == 0) begin
          chk("nb_unexpected_valid", 128'(bus.nb_valid), 128'(0));
        end else begin
          chk("nb_i", 128'(bus.nb_i), 128'(exp_q[0].i));
          chk("nb_j", 128'(bus.nb_j), 128'(exp_q[0].j));
          chk("nb_k", 128'(bus.nb_k), 128'(exp_q[0].k));
          chk("nb_scores", 128'(bus.nb_scores), 128'(exp_q[0].sc));
          if (bus.nb_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.res_valid && bus.res_ready && res_q.size() > 0) void'(res_q.pop_front());
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic launch(int ni, int nj, int nk, bit directed, int stall);
    exp_q.delete();
    res_q.delete();
    build_model(ni, nj, nk, directed);
    stall_len = stall;
    done_cnt  = 0;
    drv_en    = 1'b1;
    @(posedge clk); #1;
    cfg_ni = 5'(ni); cfg_nj = 5'(nj); cfg_nk = 5'(nk);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_ni = 5'($urandom_range(0, 4));
    cfg_nj = 5'($urandom_range(0, 4));
    cfg_nk = 5'($urandom_range(0, 4));
    // A second start while busy must not disturb the sweep.
    if (busy) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic finish_run(string name);
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_pulses"}, 128'(done_cnt), 128'(1));
    chk({name, "_nb_left"}, 128'(exp_q.size()), 128'(0));
    chk({name, "_res_left"}, 128'(res_q.size()), 128'(0));
    chk({name, "_busy_after"}, 128'(busy), 128'(0));
    if (busy) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic run_cfg(string name, int ni, int nj, int nk, bit directed, int stall);
    launch(ni, nj, nk, directed, stall);
    finish_run(name);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    cfg_ni = '0;
    cfg_nj = '0;
    cfg_nk = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_nb_valid", 128'(bus.nb_valid), 128'(0));
    chk("rst_res_ready", 128'(bus.res_ready), 128'(0));
    chk("rst_nb_scores", 128'(bus.nb_scores), 128'(0));
    chk("rst_nb_i", 128'(bus.nb_i), 128'(0));
    chk("rst_nb_j", 128'(bus.nb_j), 128'(0));
    chk("rst_nb_k", 128'(bus.nb_k), 128'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_cfg("sweep111", 1, 1, 1, 1'b0, 0);
    run_cfg("reuse", 2, 0, 0, 1'b1, 2);
    run_cfg("backpressure", 1, 1, 1, 1'b0, 5);
    run_cfg("boundary", 1, 2, 1, 1'b0, 1);
    run_cfg("ni_zero", 0, 2, 2, 1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      run_cfg($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b0, $urandom_range(0, 5));
    end

    // Reset while waiting for a result: the in-flight cell is dropped.
    launch(1, 1, 1, 1'b0, 0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.res_ready) break;
    end
    chk("wr_reached_wait_res", 128'(bus.res_ready), 128'(1));
    mon_en = 1'b0;
    drv_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("wr_rst_busy", 128'(busy), 128'(0));
    chk("wr_rst_res_ready", 128'(bus.res_ready), 128'(0));
    chk("wr_rst_nb_valid", 128'(bus.nb_valid), 128'(0));
    rst_n = 1'b1;
    exp_q.delete();
    res_q.delete();
    mon_en = 1'b1;
    run_cfg("after_reset", 2, 1, 2, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
